prince_round_ctrl: RTL and testbench
====================================

# prince_round_ctrl

Round controller for the first-order masked (GLM, d=1) PRINCE encryption core. Sequences the shared state register, the pipelined masked S-box layer built from enable-gated register stages, and the final output register. Accepts a start request, runs a fixed number of S-box rounds, and presents the result through a valid/ready handshake. It drives only the datapath's enable, select and index lines and never touches share data, so it adds no leakage paths.

## Interface
- NUM_ROUNDS, 12: number of S-box layers (forward, middle and inverse); must be even and ≥2.
- SBOX_LAT, 2: register stages inside the masked S-box; each round lasts SBOX_LAT cycles; ≥1.
- RCW, $clog2(NUM_ROUNDS+2): width of rc_idx.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a new encryption; sampled only in IDLE.
- in_ready  out  1  high in IDLE only.
- load_sel  out  1  state-register input mux: 1 = plaintext shares ⊕ whitening key, 0 = round output.
- state_en  out  1  state-register enable.
- sbox_en  out  SBOX_LAT  per-stage enable of the S-box register stages; bit i = stage i.
- rnd_en  out  1  fresh-randomness request; high whenever any sbox_en bit is high.
- rc_idx  out  RCW  round-constant index.
- inv_sel  out  1  0 = forward round structure, 1 = inverse round structure.
- mid_sel  out  1  high in the last forward round; selects M' instead of M.
- out_en  out  1  output-register enable.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, LOAD, ROUND, FINAL, DONE.
- Counters:
  - round counter r, 0..NUM_ROUNDS-1.
  - sub-cycle counter s, 0..SBOX_LAT-1.
- IDLE: in_ready=1 and all other outputs 0. start=1 moves to LOAD.
- LOAD: one cycle. load_sel=1, state_en=1, rc_idx=0. Next state ROUND with r=0, s=0.
- ROUND: sbox_en bit s = 1, all other bits 0; rnd_en=1.
  - rc_idx=r+1. inv_sel=(r ≥ NUM_ROUNDS/2). mid_sel=(r == NUM_ROUNDS/2-1).
  - state_en=1 only when s=SBOX_LAT-1; load_sel=0.
  - When s=SBOX_LAT-1: s wraps to 0 and r increments.
  - At r=NUM_ROUNDS-1 and s=SBOX_LAT-1: next state FINAL.
- FINAL: one cycle. out_en=1, rc_idx=NUM_ROUNDS+1, inv_sel=1. Next state DONE.
- DONE: out_valid=1 and held until out_ready=1; on acceptance the next state is IDLE.
- start outside IDLE is ignored and is not queued.
- out_ready outside DONE is ignored.
- All outputs are Moore: decoded from registered state and counters only, with no combinational path from start or out_ready.

## Timing
- Reset: state=IDLE, r=0, s=0. Outputs: in_ready=1; load_sel, state_en, sbox_en, rnd_en, rc_idx, inv_sel, mid_sel, out_en and out_valid all 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately (asynchronous), all enables drop to 0 in the same cycle, and the run is lost.
- Cycle numbering: cycle 0 = IDLE with start=1.
  - Cycle 1: LOAD.
  - Cycles 2..1+NUM_ROUNDS·SBOX_LAT: ROUND.
  - Cycle 2+NUM_ROUNDS·SBOX_LAT: FINAL.
  - Cycle 3+NUM_ROUNDS·SBOX_LAT: DONE, first cycle with out_valid=1. This is cycle 27 at the defaults.
- out_valid and out_ready both high in cycle t: in_ready=1 in cycle t+1.
  - Back-to-back: start sampled in cycle t+1 puts LOAD in cycle t+2.
- SBOX_LAT=1: sbox_en=1 and state_en=1 in every ROUND cycle.
- Exactly NUM_ROUNDS state_en pulses occur in ROUND, plus 1 in LOAD.
- Exactly one out_en pulse occurs per run.

## Test plan
- Defaults, start pulse in cycle 0:
  - LOAD in cycle 1, out_en in cycle 26, out_valid in cycle 27.
  - state_en high in cycles 1, 3, 5, …, 25 (13 pulses).
  - rc_idx steps 0, 1, 1, 2, 2, …, 12, 12, 13.
- Phase selects at defaults: mid_sel high only in cycles 12–13 (r=5); inv_sel low in cycles 2–13 and high in cycles 14–26.
- S-box stages at defaults: sbox_en alternates 01, 10 through the ROUND cycles; rnd_en high exactly in cycles 2–25.
- Output handshake: out_ready held low for 5 cycles after out_valid → out_valid stays 1 for those cycles. Then out_ready=1 with start=1 held → IDLE for one cycle, second LOAD 2 cycles after acceptance.
- Ignored start: start pulsed during ROUND and DONE → no effect on counters or outputs, and no extra run.
- Reset mid-operation, plus minimum latency:
  - rst asserted in cycle 10 → same cycle in_ready=1, all enables 0. After release with start=1, a full run completes with the cycle-0 timing above.
  - Build with SBOX_LAT=1, NUM_ROUNDS=2: out_valid in cycle 5.

Source files
------------

// File: rtl/prince_round_ctrl.sv
// -----------------------------------------------------------------------------
// prince_round_ctrl
//
// Round sequencer for the first-order masked PRINCE core. It drives only the
// enable, select and index lines of the datapath: state register, pipelined
// masked S-box stages and output register. It never sees share data.
//
// A run is LOAD (whitened plaintext into the state register), then NUM_ROUNDS
// S-box layers of SBOX_LAT cycles each, then FINAL (output register capture),
// then DONE until the consumer accepts the result.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      start request, sampled only in IDLE
//   i_out_ready  consumer accepts result, sampled only in DONE
//   o_in_ready   high in IDLE only
//   o_load_sel   state mux: 1 = plaintext shares ^ whitening key, 0 = round out
//   o_state_en   state register enable
//   o_sbox_en    per-stage S-box register enables, bit i = stage i
//   o_rnd_en     fresh randomness request, high with any S-box stage enable
//   o_rc_idx     round constant index
//   o_inv_sel    0 = forward round structure, 1 = inverse
//   o_mid_sel    last forward round, selects M' instead of M
//   o_out_en     output register enable
//   o_out_valid  result available
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start, o_in_ready high
// LOAD  | one cycle, state register takes plaintext ^ whitening key
// ROUND | r = round 0..NUM_ROUNDS-1, s = S-box stage 0..SBOX_LAT-1
// FINAL | one cycle, output register captures the result
// DONE  | o_out_valid held until i_out_ready
// -----------------------------------------------------------------------------
module prince_round_ctrl #(
  parameter int NUM_ROUNDS = 12,
  parameter int SBOX_LAT   = 2,
  parameter int RCW        = $clog2(NUM_ROUNDS + 2)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_in_ready,
  output logic                o_load_sel,
  output logic                o_state_en,
  output logic [SBOX_LAT-1:0] o_sbox_en,
  output logic                o_rnd_en,
  output logic [RCW-1:0]      o_rc_idx,
  output logic                o_inv_sel,
  output logic                o_mid_sel,
  output logic                o_out_en,
  output logic                o_out_valid,
  input  logic                i_out_ready
);

  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int SW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;

  localparam logic [RW-1:0]  R_LAST = RW'(NUM_ROUNDS - 1);
  localparam logic [RW-1:0]  R_MID  = RW'(NUM_ROUNDS / 2 - 1);
  localparam logic [RW-1:0]  R_HALF = RW'(NUM_ROUNDS / 2);
  localparam logic [SW-1:0]  S_LAST = SW'(SBOX_LAT - 1);
  localparam logic [RCW-1:0] RC_FIN = RCW'(NUM_ROUNDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_rnd;
  logic [RW-1:0] w_rnd_nxt;
  logic [SW-1:0] r_sub;
  logic [SW-1:0] w_sub_nxt;

  logic                w_in_ready;
  logic                w_load_sel;
  logic                w_state_en;
  logic [SBOX_LAT-1:0] w_sbox_en;
  logic                w_rnd_en;
  logic [RCW-1:0]      w_rc_idx;
  logic                w_inv_sel;
  logic                w_mid_sel;
  logic                w_out_en;
  logic                w_out_valid;

  // Next state and counters.
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_sub_nxt   = r_sub;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
          w_rnd_nxt   = '0;
          w_sub_nxt   = '0;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_ROUND;
        w_rnd_nxt   = '0;
        w_sub_nxt   = '0;
      end
      ST_ROUND: begin
        if (r_sub == S_LAST) begin
          w_sub_nxt = '0;
          if (r_rnd == R_LAST) begin
            w_state_nxt = ST_FINAL;
            w_rnd_nxt   = '0;
          end else begin
            w_rnd_nxt = r_rnd + 1'b1;
          end
        end else begin
          w_sub_nxt = r_sub + 1'b1;
        end
      end
      ST_FINAL: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rnd_nxt   = '0;
        w_sub_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state/counters and registered, so each
  // output register holds exactly the Moore decode of the current state with
  // no combinational path from the inputs.
  always_comb begin
    w_in_ready  = 1'b0;
    w_load_sel  = 1'b0;
    w_state_en  = 1'b0;
    w_sbox_en   = '0;
    w_rnd_en    = 1'b0;
    w_rc_idx    = '0;
    w_inv_sel   = 1'b0;
    w_mid_sel   = 1'b0;
    w_out_en    = 1'b0;
    w_out_valid = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_in_ready = 1'b1;
      end
      ST_LOAD: begin
        w_load_sel = 1'b1;
        w_state_en = 1'b1;
      end
      ST_ROUND: begin
        // One-hot stage enable walks through the S-box pipeline; the state
        // register only captures once the last stage has been filled.
        w_sbox_en  = SBOX_LAT'(1) << w_sub_nxt;
        w_rnd_en   = 1'b1;
        w_rc_idx   = RCW'(w_rnd_nxt) + RCW'(1);
        w_inv_sel  = (w_rnd_nxt >= R_HALF);
        w_mid_sel  = (w_rnd_nxt == R_MID);
        w_state_en = (w_sub_nxt == S_LAST);
      end
      ST_FINAL: begin
        w_out_en  = 1'b1;
        w_rc_idx  = RC_FIN;
        w_inv_sel = 1'b1;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
      end
      default: begin
        w_in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rnd       <= '0;
      r_sub       <= '0;
      o_in_ready  <= 1'b1;
      o_load_sel  <= 1'b0;
      o_state_en  <= 1'b0;
      o_sbox_en   <= '0;
      o_rnd_en    <= 1'b0;
      o_rc_idx    <= '0;
      o_inv_sel   <= 1'b0;
      o_mid_sel   <= 1'b0;
      o_out_en    <= 1'b0;
      o_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rnd       <= w_rnd_nxt;
      r_sub       <= w_sub_nxt;
      o_in_ready  <= w_in_ready;
      o_load_sel  <= w_load_sel;
      o_state_en  <= w_state_en;
      o_sbox_en   <= w_sbox_en;
      o_rnd_en    <= w_rnd_en;
      o_rc_idx    <= w_rc_idx;
      o_inv_sel   <= w_inv_sel;
      o_mid_sel   <= w_mid_sel;
      o_out_en    <= w_out_en;
      o_out_valid <= w_out_valid;
    end
  end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for prince_round_ctrl. Two instances: defaults (12 rounds, 2-stage
// S-box) and the minimum build (2 rounds, 1-stage S-box). The stimulus process
// pushes the expected output vector for every cycle, taken from the cycle
// timeline of a run, plus the cycle in which out_valid must first rise. The
// monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_prince_round_ctrl;

  typedef struct packed {
    logic       in_ready;
    logic       load_sel;
    logic       state_en;
    logic [1:0] sbox;
    logic       rnd;
    logic [3:0] rc;
    logic       inv;
    logic       mid;
    logic       out_en;
    logic       out_valid;
  } ov_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic start2 = 1'b0;
  logic out_ready2 = 1'b1;

  logic       in_ready1, load_sel1, state_en1, rnd_en1, inv_sel1, mid_sel1, out_en1, out_valid1;
  logic [1:0] sbox_en1;
  logic [3:0] rc_idx1;
  logic       in_ready2, load_sel2, state_en2, rnd_en2, inv_sel2, mid_sel2, out_en2, out_valid2;
  logic [0:0] sbox_en2;
  logic [1:0] rc_idx2;

  prince_round_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_in_ready(in_ready1), .o_load_sel(load_sel1), .o_state_en(state_en1),
    .o_sbox_en(sbox_en1), .o_rnd_en(rnd_en1), .o_rc_idx(rc_idx1),
    .o_inv_sel(inv_sel1), .o_mid_sel(mid_sel1), .o_out_en(out_en1),
    .o_out_valid(out_valid1), .i_out_ready(out_ready)
  );

  prince_round_ctrl #(.NUM_ROUNDS(2), .SBOX_LAT(1)) dut_min (
    .i_clk(clk), .i_rst(rst), .i_start(start2),
    .o_in_ready(in_ready2), .o_load_sel(load_sel2), .o_state_en(state_en2),
    .o_sbox_en(sbox_en2), .o_rnd_en(rnd_en2), .o_rc_idx(rc_idx2),
    .o_inv_sel(inv_sel2), .o_mid_sel(mid_sel2), .o_out_en(out_en2),
    .o_out_valid(out_valid2), .i_out_ready(out_ready2)
  );

  always #5 clk = ~clk;

  ov_t q1[$];
  ov_t q2[$];
  int  q_done1[$];
  int  q_done2[$];
  int  cyc = 0;
  int  k1 = 0;
  int  k2 = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Expected outputs k cycles after the start cycle (k = 0 means idle).
  function automatic ov_t exp_vec(input int k, input int nr, input int sl);
    ov_t v;
    int  j, r, s;
    v = '0;
    if (k == 0) begin
      v.in_ready = 1'b1;
    end else if (k == 1) begin
      v.load_sel = 1'b1;
      v.state_en = 1'b1;
    end else if (k <= 1 + nr * sl) begin
      j = k - 2;
      r = j / sl;
      s = j % sl;
      v.sbox     = 2'(1 << s);
      v.rnd      = 1'b1;
      v.rc       = 4'(r + 1);
      v.inv      = (r >= nr / 2);
      v.mid      = (r == nr / 2 - 1);
      v.state_en = (s == sl - 1);
    end else if (k == 2 + nr * sl) begin
      v.out_en = 1'b1;
      v.rc     = 4'(nr + 1);
      v.inv    = 1'b1;
    end else begin
      v.out_valid = 1'b1;
    end
    return v;
  endfunction

  task automatic step(input logic st, input logic rdy, input logic rs, input logic st2);
    @(posedge clk);
    #1;
    cyc++;
    rst       = rs;
    start     = st;
    out_ready = rdy;
    start2    = st2;
    if (rs) begin
      k1 = 0;
      k2 = 0;
      q_done1.delete();
      q_done2.delete();
    end
    q1.push_back(exp_vec(k1, 12, 2));
    q2.push_back(exp_vec(k2, 2, 1));
    if (!rs) begin
      // defaults: DONE is 27 cycles after the start cycle
      if (k1 == 0) begin
        if (st) begin
          k1 = 1;
          q_done1.push_back(cyc + 27);
        end
      end else if (k1 < 27) begin
        k1++;
      end else if (rdy) begin
        k1 = 0;
      end
      // minimum build: DONE 5 cycles after the start cycle
      if (k2 == 0) begin
        if (st2) begin
          k2 = 1;
          q_done2.push_back(cyc + 5);
        end
      end else if (k2 < 5) begin
        k2++;
      end else if (out_ready2) begin
        k2 = 0;
      end
    end
  endtask

  // Monitor
  logic pv1 = 1'b0;
  logic pv2 = 1'b0;
  int   se1 = 0;
  int   se2 = 0;

  always @(negedge clk) begin
    ov_t a, e;
    int  ec;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {in_ready1, load_sel1, state_en1, sbox_en1, rnd_en1, rc_idx1,
           inv_sel1, mid_sel1, out_en1, out_valid1};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outs_default cyc %0d: got %h expected %h", cyc, a, e);
      end
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      a = {in_ready2, load_sel2, state_en2, 1'b0, sbox_en2, rnd_en2, 2'b00, rc_idx2,
           inv_sel2, mid_sel2, out_en2, out_valid2};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL outs_min cyc %0d: got %h expected %h", cyc, a, e);
      end
    end

    if (load_sel1) se1 = 1;
    else if (state_en1) se1++;
    if (load_sel2) se2 = 1;
    else if (state_en2) se2++;

    if (out_valid1 && !pv1) begin
      n_checks++;
      if (q_done1.size() == 0) begin
        n_errors++;
        $display("FAIL valid_default cyc %0d: got out_valid rise expected none", cyc);
      end else begin
        ec = q_done1.pop_front();
        if (cyc != ec) begin
          n_errors++;
          $display("FAIL valid_default_cycle: got %0d expected %0d", cyc, ec);
        end
      end
      n_checks++;
      if (se1 != 13) begin
        n_errors++;
        $display("FAIL state_en_pulses_default: got %0d expected 13", se1);
      end
    end
    if (out_valid2 && !pv2) begin
      n_checks++;
      if (q_done2.size() == 0) begin
        n_errors++;
        $display("FAIL valid_min cyc %0d: got out_valid rise expected none", cyc);
      end else begin
        ec = q_done2.pop_front();
        if (cyc != ec) begin
          n_errors++;
          $display("FAIL valid_min_cycle: got %0d expected %0d", cyc, ec);
        end
      end
      n_checks++;
      if (se2 != 3) begin
        n_errors++;
        $display("FAIL state_en_pulses_min: got %0d expected 3", se2);
      end
    end
    pv1 = out_valid1;
    pv2 = out_valid2;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // reset held, then idle
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

    // run A on both instances; extra start in ROUND is ignored
    step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (18) step(1'b0, 1'b0, 1'b0, 1'b0);
    // DONE with out_ready low for 5 cycles, start pulsed inside DONE
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // accept with start held: IDLE next cycle, LOAD two cycles after accept
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    // run B completes with out_ready high throughout
    repeat (30) step(1'b0, 1'b1, 1'b0, 1'b0);

    // run C aborted by reset in its cycle 10
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // run D right after release
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (26) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q_done1.size() != 0) begin
      n_errors++;
      $display("FAIL pending_valid_default: got %0d outstanding expected 0", q_done1.size());
    end
    n_checks++;
    if (q_done2.size() != 0) begin
      n_errors++;
      $display("FAIL pending_valid_min: got %0d outstanding expected 0", q_done2.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
